// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: tq prescaler, SYNC/SEG1/SEG2 sequencing, hard sync and resync.
// Optional majority-of-three sampling over the last three SEG1 tq when CAN_TRIPLE_SAMPLE_EN is defined.
module can_bit_timing #(
    parameter int BRP_W   = 6,
    parameter int TSEG1_W = 4,
    parameter int TSEG2_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_raw,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [1:0]         sjw,
    input  logic               hard_sync_en,
    output logic               rx_bit,
    output logic               sample_point,
    output logic               tx_point
);

    localparam int CW = TSEG1_W + 1;

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_SEG1 = 2'd1;
    localparam logic [1:0] ST_SEG2 = 2'd2;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [1:0]         r_state;
    logic [BRP_W-1:0]   r_presc;
    logic [CW-1:0]      r_idx;
    logic [CW-1:0]      r_last;
    logic [BRP_W-1:0]   r_brp;
    logic [TSEG1_W-1:0] r_tseg1;
    logic [TSEG2_W-1:0] r_tseg2;
    logic [1:0]         r_sjw;
    logic               r_rx_bit;
    logic               r_resynced;

    logic               w_edge;
    logic               w_resync_ok;
    logic [CW-1:0]      w_sjw;
    logic [CW-1:0]      w_e1;
    logic [CW-1:0]      w_e2;
    logic [CW-1:0]      w_ext;
    logic               w_seg1_ext;
    logic               w_seg2_res;
    logic               w_imm;
    logic               w_shorten;
    logic               w_hs;
    logic [1:0]         w_state_c;
    logic [BRP_W-1:0]   w_presc_c;
    logic [BRP_W-1:0]   w_brp_c;
    logic [CW-1:0]      w_idx_c;
    logic [CW-1:0]      w_last_c;
    logic [TSEG1_W-1:0] w_tseg1_c;
    logic               w_tick;
    logic               w_seg_end;
    logic               w_sample;
    logic               w_enter_sync;
    logic               w_sample_val;

    // Edge is seen one clock after the second synchronizer flop goes low.
    assign w_edge      = r_sync3 & ~r_sync2;
    assign w_resync_ok = w_edge & ~hard_sync_en & r_rx_bit & ~r_resynced & ~reset;

    assign w_sjw = {{(CW-2){1'b0}}, r_sjw} + CW'(1);
    assign w_e1  = r_idx + CW'(1);
    assign w_e2  = r_last - r_idx + CW'(1);
    assign w_ext = (w_e1 < w_sjw) ? w_e1 : w_sjw;

    assign w_seg1_ext = w_resync_ok && (r_state == ST_SEG1);
    assign w_seg2_res = w_resync_ok && (r_state == ST_SEG2);
    assign w_imm      = w_seg2_res && (w_e2 <= w_sjw);
    assign w_shorten  = w_seg2_res && !w_imm;
    assign w_hs       = ~reset & ((w_edge & hard_sync_en) | w_imm);

    // Effective position for this clock: a hard/immediate sync makes it the first clock of SYNC.
    always_comb begin
        w_state_c = r_state;
        w_presc_c = r_presc;
        w_brp_c   = r_brp;
        w_idx_c   = r_idx;
        w_last_c  = r_last;
        w_tseg1_c = r_tseg1;
        if (w_seg1_ext) begin
            w_last_c = r_last + w_ext;
        end
        if (w_shorten) begin
            w_last_c = r_last - w_sjw;
        end
        if (w_hs) begin
            w_state_c = ST_SYNC;
            w_presc_c = '0;
            w_brp_c   = brp;
            w_idx_c   = '0;
            w_last_c  = '0;
            w_tseg1_c = tseg1;
        end
    end

    assign w_tick       = (w_presc_c == w_brp_c);
    assign w_seg_end    = w_tick && (w_idx_c == w_last_c);
    assign w_sample     = ~reset && w_seg_end && (w_state_c == ST_SEG1);
    assign w_enter_sync = w_hs || (w_seg_end && (w_state_c == ST_SEG2));

`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0] r_cap;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cap <= 2'b11;
        end else if (w_tick && (w_state_c == ST_SEG1)) begin
            r_cap <= {r_cap[0], r_sync2};
        end
    end

    assign w_sample_val = (r_cap[1] & r_cap[0]) | (r_cap[1] & r_sync2) | (r_cap[0] & r_sync2);
`else
    assign w_sample_val = r_sync2;
`endif

    assign sample_point = w_sample;
    assign rx_bit       = w_sample ? w_sample_val : r_rx_bit;
    assign tx_point     = ~reset && (w_state_c == ST_SYNC) && (w_presc_c == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync3    <= 1'b1;
            r_state    <= ST_SYNC;
            r_presc    <= '0;
            r_idx      <= '0;
            r_last     <= '0;
            r_rx_bit   <= 1'b1;
            r_resynced <= 1'b0;
            r_brp      <= brp;
            r_tseg1    <= tseg1;
            r_tseg2    <= tseg2;
            r_sjw      <= sjw;
        end else begin
            r_sync1 <= rx_raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            if (w_enter_sync) begin
                r_brp   <= brp;
                r_tseg1 <= tseg1;
                r_tseg2 <= tseg2;
                r_sjw   <= sjw;
            end

            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= w_presc_c + 1'b1;
            end

            if (w_seg_end) begin
                r_idx <= '0;
                case (w_state_c)
                    ST_SYNC: begin
                        r_state <= ST_SEG1;
                        r_last  <= {1'b0, w_tseg1_c};
                    end
                    ST_SEG1: begin
                        r_state <= ST_SEG2;
                        r_last  <= {{(CW-TSEG2_W){1'b0}}, r_tseg2};
                    end
                    default: begin
                        r_state <= ST_SYNC;
                        r_last  <= '0;
                    end
                endcase
            end else begin
                r_state <= w_state_c;
                r_last  <= w_last_c;
                if (w_tick) begin
                    r_idx <= w_idx_c + CW'(1);
                end else begin
                    r_idx <= w_idx_c;
                end
            end

            if (w_sample) begin
                r_rx_bit <= w_sample_val;
            end

            // Only one resync per bit; the allowance returns at each sample point.
            if (w_sample) begin
                r_resynced <= 1'b0;
            end else if (w_seg1_ext || w_seg2_res) begin
                r_resynced <= 1'b1;
            end
        end
    end

endmodule
